// File: rtl/mult_acc_pipe.sv
// mult_acc_pipe: pipelined multiply-accumulate with optional input, product and
// output registers, per-operand dynamic signedness and a sticky overflow flag.

module mult_acc_pipe_chk #(
    parameter int ACC_WIDTH = 48
) (
    input  logic                 CLK0,
    input  logic                 RST0,
    input  logic                 CE0,
    input  logic                 OUT_VALID,
    input  logic                 OVF,
    input  logic [ACC_WIDTH-1:0] P
);
    a_reset_clears: assert property (@(posedge CLK0)
        RST0 |=> (!OUT_VALID && !OVF && (P == {ACC_WIDTH{1'b0}})));

    // A stalled edge never produces a result strobe
    a_stall_no_strobe: assert property (@(posedge CLK0)
        (!RST0 && !CE0) |=> !OUT_VALID);
endmodule

module mult_acc_pipe #(
    parameter int A_WIDTH      = 18,
    parameter int B_WIDTH      = 18,
    parameter int ACC_WIDTH    = 48,
    parameter int REG_INPUT    = 1,
    parameter int REG_PIPELINE = 1,
    parameter int REG_OUTPUT   = 1
) (
    input  logic                 CLK0,
    input  logic                 RST0,
    input  logic                 CE0,
    input  logic [A_WIDTH-1:0]   A,
    input  logic [B_WIDTH-1:0]   B,
    input  logic                 SIGNEDA,
    input  logic                 SIGNEDB,
    input  logic                 IN_VALID,
    input  logic                 ACC_EN,
    output logic [ACC_WIDTH-1:0] P,
    output logic                 OUT_VALID,
    output logic                 OVF
);
    localparam int PW = A_WIDTH + B_WIDTH;

    // Overflow of one accumulate step: two's-complement rule or carry-out
    function automatic logic add_overflow(
        input logic                 signed_mode,
        input logic [ACC_WIDTH-1:0] x,
        input logic [ACC_WIDTH-1:0] y,
        input logic [ACC_WIDTH:0]   sum
    );
        logic same_sign;
        same_sign = (x[ACC_WIDTH-1] == y[ACC_WIDTH-1]);
        return signed_mode ? (same_sign && (sum[ACC_WIDTH-1] != x[ACC_WIDTH-1]))
                           : sum[ACC_WIDTH];
    endfunction

    logic [A_WIDTH-1:0]   a_q_s;
    logic [B_WIDTH-1:0]   b_q_s;
    logic                 sa_q_s, sb_q_s, ae_q_s, v_q_s;
    logic [PW-1:0]        a_w_s, b_w_s, prod_s;
    logic [PW-1:0]        prod_m_s;
    logic                 sa_m_s, sb_m_s, ae_m_s, v_m_s;
    logic                 sign_mode_s;
    logic [ACC_WIDTH-1:0] prod_ext_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 add_ovf_s;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 ovf_r;

    generate
        if (REG_INPUT != 0) begin : g_in_reg
            logic [A_WIDTH-1:0] a_r;
            logic [B_WIDTH-1:0] b_r;
            logic               sa_r, sb_r, ae_r, v_r;

            // Input capture of operands, signedness and mode
            always_ff @(posedge CLK0) begin
                if (RST0) begin
                    a_r  <= {A_WIDTH{1'b0}};
                    b_r  <= {B_WIDTH{1'b0}};
                    sa_r <= 1'b0;
                    sb_r <= 1'b0;
                    ae_r <= 1'b0;
                    v_r  <= 1'b0;
                end else if (CE0) begin
                    a_r  <= A;
                    b_r  <= B;
                    sa_r <= SIGNEDA;
                    sb_r <= SIGNEDB;
                    ae_r <= ACC_EN;
                    v_r  <= IN_VALID;
                end
            end

            assign a_q_s  = a_r;
            assign b_q_s  = b_r;
            assign sa_q_s = sa_r;
            assign sb_q_s = sb_r;
            assign ae_q_s = ae_r;
            assign v_q_s  = v_r;
        end else begin : g_in_comb
            assign a_q_s  = A;
            assign b_q_s  = B;
            assign sa_q_s = SIGNEDA;
            assign sb_q_s = SIGNEDB;
            assign ae_q_s = ACC_EN;
            assign v_q_s  = IN_VALID;
        end
    endgenerate

    // Operand extension to PW bits; the true product always fits PW bits, so the
    // low PW bits of a PW x PW multiply are exact for every signedness mix.
    always_comb begin
        a_w_s  = {{B_WIDTH{sa_q_s & a_q_s[A_WIDTH-1]}}, a_q_s};
        b_w_s  = {{A_WIDTH{sb_q_s & b_q_s[B_WIDTH-1]}}, b_q_s};
        prod_s = a_w_s * b_w_s;
    end

    generate
        if (REG_PIPELINE != 0) begin : g_pipe_reg
            logic [PW-1:0] prod_r;
            logic          sa_r, sb_r, ae_r, v_r;

            // Raw product register with the sample's control bits
            always_ff @(posedge CLK0) begin
                if (RST0) begin
                    prod_r <= {PW{1'b0}};
                    sa_r   <= 1'b0;
                    sb_r   <= 1'b0;
                    ae_r   <= 1'b0;
                    v_r    <= 1'b0;
                end else if (CE0) begin
                    prod_r <= prod_s;
                    sa_r   <= sa_q_s;
                    sb_r   <= sb_q_s;
                    ae_r   <= ae_q_s;
                    v_r    <= v_q_s;
                end
            end

            assign prod_m_s = prod_r;
            assign sa_m_s   = sa_r;
            assign sb_m_s   = sb_r;
            assign ae_m_s   = ae_r;
            assign v_m_s    = v_r;
        end else begin : g_pipe_comb
            assign prod_m_s = prod_s;
            assign sa_m_s   = sa_q_s;
            assign sb_m_s   = sb_q_s;
            assign ae_m_s   = ae_q_s;
            assign v_m_s    = v_q_s;
        end
    endgenerate

    assign sign_mode_s = sa_m_s | sb_m_s;

    generate
        if (ACC_WIDTH > PW) begin : g_ext
            assign prod_ext_s = {{(ACC_WIDTH-PW){sign_mode_s & prod_m_s[PW-1]}}, prod_m_s};
        end else begin : g_noext
            assign prod_ext_s = prod_m_s;
        end
    endgenerate

    // Accumulator adder and overflow detection
    always_comb begin
        sum_s     = {1'b0, acc_r} + {1'b0, prod_ext_s};
        add_ovf_s = add_overflow(sign_mode_s, acc_r, prod_ext_s, sum_s);
    end

    // Accumulator: load or add on valid samples, bubbles leave it untouched
    always_ff @(posedge CLK0) begin
        if (RST0) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            ovf_r <= 1'b0;
        end else if (CE0 && v_m_s) begin
            if (ae_m_s) begin
                acc_r <= sum_s[ACC_WIDTH-1:0];
                ovf_r <= ovf_r | add_ovf_s;
            end else begin
                acc_r <= prod_ext_s;
                ovf_r <= 1'b0;
            end
        end
    end

    generate
        if (REG_OUTPUT != 0) begin : g_out_reg
            logic                 acc_vld_r;
            logic                 out_valid_r;
            logic                 ovf_o_r;
            logic [ACC_WIDTH-1:0] p_r;

            // Output stage; the strobe drops on stalled edges so no sample repeats
            always_ff @(posedge CLK0) begin
                if (RST0) begin
                    acc_vld_r   <= 1'b0;
                    out_valid_r <= 1'b0;
                    ovf_o_r     <= 1'b0;
                    p_r         <= {ACC_WIDTH{1'b0}};
                end else if (CE0) begin
                    acc_vld_r   <= v_m_s;
                    out_valid_r <= acc_vld_r;
                    ovf_o_r     <= ovf_r;
                    p_r         <= acc_r;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end

            assign P         = p_r;
            assign OVF       = ovf_o_r;
            assign OUT_VALID = out_valid_r;
        end else begin : g_out_direct
            logic upd_r;

            // Strobe marking an accumulator update on the last edge
            always_ff @(posedge CLK0) begin
                if (RST0) begin
                    upd_r <= 1'b0;
                end else begin
                    upd_r <= CE0 & v_m_s;
                end
            end

            assign P         = acc_r;
            assign OVF       = ovf_r;
            assign OUT_VALID = upd_r;
        end
    endgenerate

    mult_acc_pipe_chk #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_chk (
        .CLK0      (CLK0),
        .RST0      (RST0),
        .CE0       (CE0),
        .OUT_VALID (OUT_VALID),
        .OVF       (OVF),
        .P         (P)
    );
endmodule

// File: tb/tb_mult_acc_pipe.sv
// Bench for mult_acc_pipe: six configurations share one stimulus stream and are
// each compared every cycle against an arithmetic reference model.

module tb_mult_acc_pipe;
    localparam int N = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b1;
    logic [17:0] a   = 18'd0;
    logic [17:0] b   = 18'd0;
    logic        sa  = 1'b0;
    logic        sb  = 1'b0;
    logic        iv  = 1'b0;
    logic        ae  = 1'b0;

    logic [47:0] p_obs   [N];
    logic        ov_obs  [N];
    logic        ovf_obs [N];
    logic [39:0] p40;

    int lat [N] = '{4, 1, 2, 3, 3, 4};
    int wid [N] = '{48, 48, 48, 48, 48, 40};

    longint acc_m  [N];
    logic   ovf_m  [N];
    logic   slot_v [N][8];
    longint slot_p [N][8];
    logic   slot_o [N][8];
    logic   exp_v  [N];
    longint exp_p  [N];
    logic   exp_o  [N];
    int     en_cnt   = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk = ~clk;

    mult_acc_pipe #(.REG_INPUT(1), .REG_PIPELINE(1), .REG_OUTPUT(1)) dut0 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p_obs[0]), .OUT_VALID(ov_obs[0]), .OVF(ovf_obs[0]));
    mult_acc_pipe #(.REG_INPUT(0), .REG_PIPELINE(0), .REG_OUTPUT(0)) dut1 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p_obs[1]), .OUT_VALID(ov_obs[1]), .OVF(ovf_obs[1]));
    mult_acc_pipe #(.REG_INPUT(1), .REG_PIPELINE(0), .REG_OUTPUT(0)) dut2 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p_obs[2]), .OUT_VALID(ov_obs[2]), .OVF(ovf_obs[2]));
    mult_acc_pipe #(.REG_INPUT(1), .REG_PIPELINE(1), .REG_OUTPUT(0)) dut3 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p_obs[3]), .OUT_VALID(ov_obs[3]), .OVF(ovf_obs[3]));
    mult_acc_pipe #(.REG_INPUT(0), .REG_PIPELINE(1), .REG_OUTPUT(1)) dut4 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p_obs[4]), .OUT_VALID(ov_obs[4]), .OVF(ovf_obs[4]));
    mult_acc_pipe #(.ACC_WIDTH(40)) dut5 (
        .CLK0(clk), .RST0(rst), .CE0(ce), .A(a), .B(b), .SIGNEDA(sa), .SIGNEDB(sb),
        .IN_VALID(iv), .ACC_EN(ae), .P(p40), .OUT_VALID(ov_obs[5]), .OVF(ovf_obs[5]));

    assign p_obs[5] = {8'd0, p40};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mathematical accumulate of one sample into configuration i
    task automatic model_apply(input int i);
        longint av, bv, prod, md, lim, cur, s;
        av = longint'(a);
        bv = longint'(b);
        if (sa && a[17]) av = av - 64'sd262144;
        if (sb && b[17]) bv = bv - 64'sd262144;
        prod = av * bv;
        md   = 64'sd1 <<< wid[i];
        lim  = md / 64'sd2;
        if (!ae) begin
            acc_m[i] = prod & (md - 64'sd1);
            ovf_m[i] = 1'b0;
        end else if (sa || sb) begin
            cur = (acc_m[i] >= lim) ? acc_m[i] - md : acc_m[i];
            s   = cur + prod;
            if (s >= lim || s < -lim) ovf_m[i] = 1'b1;
            acc_m[i] = s & (md - 64'sd1);
        end else begin
            s = acc_m[i] + prod;
            if (s >= md) ovf_m[i] = 1'b1;
            acc_m[i] = s & (md - 64'sd1);
        end
    endtask

    // Reference behaviour at one clock edge: samples emerge L enabled edges later
    task automatic model_edge();
        int k;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                acc_m[i] = 0; ovf_m[i] = 1'b0;
                exp_v[i] = 1'b0; exp_p[i] = 0; exp_o[i] = 1'b0;
                for (int j = 0; j < 8; j++) slot_v[i][j] = 1'b0;
            end
        end else if (ce) begin
            en_cnt++;
            for (int i = 0; i < N; i++) begin
                if (iv) begin
                    model_apply(i);
                    k = (en_cnt + lat[i] - 1) % 8;
                    slot_v[i][k] = 1'b1;
                    slot_p[i][k] = acc_m[i];
                    slot_o[i][k] = ovf_m[i];
                end
                k = en_cnt % 8;
                exp_v[i] = slot_v[i][k];
                if (slot_v[i][k]) begin
                    exp_p[i] = slot_p[i][k];
                    exp_o[i] = slot_o[i][k];
                end
                slot_v[i][k] = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) exp_v[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("out_valid[%0d]", i), 64'(ov_obs[i]), 64'(exp_v[i]));
            check_eq($sformatf("p[%0d]", i), 64'(p_obs[i]), 64'(exp_p[i]));
            check_eq($sformatf("ovf[%0d]", i), 64'(ovf_obs[i]), 64'(exp_o[i]));
        end
    endtask

    task automatic drive(input logic [17:0] da, input logic [17:0] db, input logic dsa,
                         input logic dsb, input logic dv, input logic dae);
        a = da; b = db; sa = dsa; sb = dsb; iv = dv; ae = dae;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(18'd0, 18'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        check_eq("reset_p", 64'(p_obs[0]), 64'd0);
        check_eq("reset_valid", 64'(ov_obs[0]), 64'd0);
        rst = 1'b0;

        drive(18'd3, 18'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("dflt_p", 64'(p_obs[0]), 64'd15);

        drive(18'h3FFFF, 18'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("signed_p", 64'(p_obs[0]), 64'hFFFF_FFFF_FFFE);
        drive(18'h3FFFF, 18'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("unsigned_p", 64'(p_obs[0]), 64'd524286);

        drive(18'd2, 18'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(18'd4, 18'd5, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        drive(18'd1, 18'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(5);
        for (int i = 0; i < N; i++) check_eq($sformatf("stream_p[%0d]", i), 64'(p_obs[i]), 64'd27);

        drive(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) drive(18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(5);
        check_eq("ovf40_p", 64'(p40), 64'h80_0000_0000);
        check_eq("ovf40_flag", 64'(ovf_obs[5]), 64'd1);
        check_eq("ovf48_flag", 64'(ovf_obs[0]), 64'd0);
        drive(18'd1, 18'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(5);
        check_eq("reload_p", 64'(p40), 64'd1);
        check_eq("reload_ovf", 64'(ovf_obs[5]), 64'd0);

        drive(18'd1, 18'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(18'd3, 18'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        drive(18'd5, 18'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(6);
        check_eq("stall_p", 64'(p_obs[0]), 64'd44);

        drive(18'd7, 18'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(18'd9, 18'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_eq("midrst_p", 64'(p_obs[0]), 64'd0);
        check_eq("midrst_ovf", 64'(ovf_obs[0]), 64'd0);
        idle(6);

        for (int n = 0; n < 3000; n++) begin
            ce  = ($urandom_range(0, 99) < 88);
            rst = ($urandom_range(0, 299) == 0);
            drive(18'($urandom()), 18'($urandom()), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 8));
        end
        rst = 1'b0;
        ce  = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
